cpu_ctrl_fsm: RTL and testbench

CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

---
 rtl/cpu_ctrl_fsm.sv | 179 +++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for a simple RV32 core.
// Optional build macro INSTRET_CNT_EN adds the retired-instruction counter.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | first cycle after reset, no memory activity
// FETCH_REQ  | imem_req_valid high, waiting for imem_req_ready
// FETCH_WAIT | request accepted, waiting for imem_rsp_valid
// DECODE     | inst latched, opcode classified, halt check
// EXECUTE    | datapath works; br_taken/br_target captured at exit
// WRITEBACK  | rf_we pulse, pc update, retire
// HALT       | stopped on ebreak or unknown opcode until rst

module cpu_ctrl_fsm #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          TYPE_W   = 3
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [31:0]       imem_addr,
   input  logic              imem_rsp_valid,
   input  logic [31:0]       imem_rsp_data,
   output logic [31:0]       pc,
   output logic [31:0]       inst,
   output logic [TYPE_W-1:0] inst_type,
   input  logic              br_taken,
   input  logic [31:0]       br_target,
   output logic              rf_we,
   output logic              halted,
   output logic              illegal,
   output logic [31:0]       instret
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_FETCH_REQ  = 3'd1,
      S_FETCH_WAIT = 3'd2,
      S_DECODE     = 3'd3,
      S_EXECUTE    = 3'd4,
      S_WRITEBACK  = 3'd5,
      S_HALT       = 3'd6
   } state_t;

   localparam logic [TYPE_W-1:0] T_R = TYPE_W'(0);
   localparam logic [TYPE_W-1:0] T_I = TYPE_W'(1);
   localparam logic [TYPE_W-1:0] T_S = TYPE_W'(2);
   localparam logic [TYPE_W-1:0] T_B = TYPE_W'(3);
   localparam logic [TYPE_W-1:0] T_U = TYPE_W'(4);
   localparam logic [TYPE_W-1:0] T_J = TYPE_W'(5);
   localparam logic [TYPE_W-1:0] T_X = TYPE_W'(7);

   localparam logic [31:0] EBREAK      = 32'h0010_0073;
   localparam logic [6:0]  OP_JALR     = 7'b1100111;

   state_t            state;
   state_t            state_nxt;
   logic [TYPE_W-1:0] dec_type;
   logic              is_ebreak;
   logic              br_taken_q;
   logic [31:0]       br_target_q;
   logic              take_target;
   logic [31:0]       pc_nxt;

   function automatic logic [TYPE_W-1:0] decode_type(input logic [6:0] op);
      logic [TYPE_W-1:0] t;
      case (op)
         7'b0110011:                                      t = T_R;
         7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:  t = T_I;
         7'b0100011:                                      t = T_S;
         7'b1100011:                                      t = T_B;
         7'b0110111, 7'b0010111:                          t = T_U;
         7'b1101111:                                      t = T_J;
         default:                                         t = T_X;
      endcase
      return t;
   endfunction

   assign dec_type  = decode_type(inst[6:0]);
   assign is_ebreak = (inst == EBREAK);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:       state_nxt = S_FETCH_REQ;
         S_FETCH_REQ:  if (imem_req_ready) state_nxt = S_FETCH_WAIT;
         S_FETCH_WAIT: if (imem_rsp_valid) state_nxt = S_DECODE;
         S_DECODE: begin
            if (is_ebreak || (dec_type == T_X)) begin
               state_nxt = S_HALT;
            end else begin
               state_nxt = S_EXECUTE;
            end
         end
         S_EXECUTE:    state_nxt = S_WRITEBACK;
         S_WRITEBACK:  state_nxt = S_FETCH_REQ;
         S_HALT:       state_nxt = S_HALT;
         default:      state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      imem_req_valid = 1'b0;
      rf_we          = 1'b0;
      case (state)
         S_FETCH_REQ: imem_req_valid = 1'b1;
         S_WRITEBACK: rf_we = (inst_type == T_R) || (inst_type == T_I) ||
                              (inst_type == T_U) || (inst_type == T_J);
         default: ;
      endcase
   end

   // jalr shares the I format, so it is picked out by opcode rather than type
   assign take_target = (inst_type == T_J) || (inst[6:0] == OP_JALR) ||
                        ((inst_type == T_B) && br_taken_q);
   assign pc_nxt      = take_target ? br_target_q : (pc + 32'd4);
   assign imem_addr   = pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC;
         inst        <= '0;
         inst_type   <= T_X;
         halted      <= 1'b0;
         illegal     <= 1'b0;
         br_taken_q  <= 1'b0;
         br_target_q <= '0;
      end else begin
         case (state)
            S_FETCH_WAIT: begin
               if (imem_rsp_valid) inst <= imem_rsp_data;
            end
            S_DECODE: begin
               inst_type <= dec_type;
               if (is_ebreak) begin
                  halted <= 1'b1;
               end else if (dec_type == T_X) begin
                  illegal <= 1'b1;
               end
            end
            S_EXECUTE: begin
               br_taken_q  <= br_taken;
               br_target_q <= br_target;
            end
            S_WRITEBACK: pc <= pc_nxt;
            default: ;
         endcase
      end
   end

`ifdef INSTRET_CNT_EN
   logic [31:0] instret_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instret_q <= '0;
      end else if (state == S_WRITEBACK) begin
         instret_q <= instret_q + 32'd1;
      end
   end

   assign instret = instret_q;
`else
   assign instret = '0;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Randomized bench for cpu_ctrl_fsm with a per-instruction reference model.
// Honors INSTRET_CNT_EN to pick the expected instret behaviour.

module tb_cpu_ctrl_fsm;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam logic [31:0] EBREAK   = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] pc;
   logic [31:0] inst;
   logic [2:0]  inst_type;
   logic        br_taken;
   logic [31:0] br_target;
   logic        rf_we;
   logic        halted;
   logic        illegal;
   logic [31:0] instret;

   int tests = 0;
   int fails = 0;
   logic [31:0] m_pc;
   logic [31:0] m_instret;

   always #5 clk = ~clk;

   cpu_ctrl_fsm #(.RESET_PC(RESET_PC), .TYPE_W(3)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .pc(pc), .inst(inst),
      .inst_type(inst_type), .br_taken(br_taken), .br_target(br_target),
      .rf_we(rf_we), .halted(halted), .illegal(illegal), .instret(instret)
   );

   // Reference: format class of an opcode
   function automatic int m_type(input logic [6:0] op);
      case (op)
         7'h33:                      return 0;
         7'h13, 7'h03, 7'h67, 7'h73: return 1;
         7'h23:                      return 2;
         7'h63:                      return 3;
         7'h37, 7'h17:               return 4;
         7'h6F:                      return 5;
         default:                    return 7;
      endcase
   endfunction

   function automatic logic [31:0] m_retire_count(input logic [31:0] n);
`ifdef INSTRET_CNT_EN
      return n;
`else
      return 32'd0;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      br_taken  = 1'b0;
      br_target = '0;
      step();
      step();
      rst = 1'b0;
      m_pc = RESET_PC;
      m_instret = '0;
   endtask

   // One instruction through the core with the given memory timing.
   task automatic run_inst(input logic [31:0] word, input logic taken,
                           input logic [31:0] target, input int rd, input int sd,
                           input bit stray, input string name);
      int          cyc;
      int          wait_cnt;
      int          ty;
      bit          exp_halt;
      bit          exp_ill;
      bit          exp_we;
      logic [31:0] exp_pc;
      logic [6:0]  op;

      op       = word[6:0];
      ty       = m_type(op);
      exp_halt = (word == EBREAK);
      exp_ill  = !exp_halt && (ty == 7);
      exp_we   = (ty == 0) || (ty == 1) || (ty == 4) || (ty == 5);
      if ((ty == 5) || (op == 7'h67) || ((ty == 3) && taken)) exp_pc = target;
      else exp_pc = m_pc + 32'd4;

      wait_cnt = 0;
      while (!imem_req_valid && wait_cnt < 40) begin
         br_taken = 1'($urandom); br_target = $urandom;
         step();
         wait_cnt++;
      end
      tests++;
      if (imem_req_valid !== 1'b1) begin
         fails++;
         $display("FAIL %s fetch_timeout: imem_req_valid=%b required 1", name, imem_req_valid);
         return;
      end
      tests++;
      if (imem_addr !== m_pc) begin
         fails++;
         $display("FAIL %s imem_addr: got %h required %h", name, imem_addr, m_pc);
      end

      cyc = 1;
      for (int k = 0; k < rd; k++) begin
         imem_req_ready = 1'b0;
         imem_rsp_valid = stray;
         imem_rsp_data  = $urandom;
         step();
         cyc++;
         tests++;
         if (imem_req_valid !== 1'b1 || imem_addr !== m_pc) begin
            fails++;
            $display("FAIL %s stall_stable: valid=%b addr=%h required 1 %h",
                     name, imem_req_valid, imem_addr, m_pc);
         end
      end
      imem_req_ready = 1'b1;
      imem_rsp_valid = stray;
      imem_rsp_data  = ~word;
      step();
      cyc++;
      imem_req_ready = 1'b0;
      for (int k = 0; k < sd; k++) begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
         tests++;
         if (imem_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s req_in_wait: valid=%b required 0", name, imem_req_valid);
         end
         step();
         cyc++;
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word;
      step();
      cyc++;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      step();
      cyc++;

      if (exp_halt || exp_ill) begin
         imem_req_ready = 1'b1;
         for (int k = 0; k < 4; k++) begin
            tests++;
            if (halted !== exp_halt || illegal !== exp_ill || imem_req_valid !== 1'b0 ||
                instret !== m_retire_count(m_instret) || pc !== m_pc) begin
               fails++;
               $display("FAIL %s halt_state: halted=%b illegal=%b valid=%b instret=%h pc=%h required %b %b 0 %h %h",
                        name, halted, illegal, imem_req_valid, instret, pc,
                        exp_halt, exp_ill, m_retire_count(m_instret), m_pc);
            end
            step();
         end
         imem_req_ready = 1'b0;
         return;
      end

      // EXECUTE cycle
      tests++;
      if (inst !== word || inst_type !== 3'(ty) || rf_we !== 1'b0 || halted || illegal) begin
         fails++;
         $display("FAIL %s execute: inst=%h type=%0d rf_we=%b required %h %0d 0",
                  name, inst, inst_type, rf_we, word, ty);
      end
      br_taken  = taken;
      br_target = target;
      step();
      cyc++;
      br_taken  = ~taken;
      br_target = ~target;
      // WRITEBACK cycle
      tests++;
      if (rf_we !== exp_we || cyc != 5 + rd + sd) begin
         fails++;
         $display("FAIL %s writeback: rf_we=%b cycle=%0d required %b %0d",
                  name, rf_we, cyc, exp_we, 5 + rd + sd);
      end
      step();
      m_pc      = exp_pc;
      m_instret = m_instret + 32'd1;
      tests++;
      if (pc !== m_pc || rf_we !== 1'b0 || instret !== m_retire_count(m_instret)) begin
         fails++;
         $display("FAIL %s retire: pc=%h rf_we=%b instret=%h required %h 0 %h",
                  name, pc, rf_we, instret, m_pc, m_retire_count(m_instret));
      end
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if (pc !== RESET_PC || inst !== 32'd0 || inst_type !== 3'd7 || imem_req_valid !== 1'b0 ||
          rf_we !== 1'b0 || halted !== 1'b0 || illegal !== 1'b0 || instret !== 32'd0) begin
         fails++;
         $display("FAIL reset_values: pc=%h inst=%h type=%0d valid=%b we=%b h=%b i=%b ir=%h",
                  pc, inst, inst_type, imem_req_valid, rf_we, halted, illegal, instret);
      end
   endtask

   task automatic test_addi();
      run_inst(32'h0050_0093, 1'b0, 32'h1234_5678, 0, 0, 1'b0, "addi");
   endtask

   task automatic test_beq_taken();
      run_inst(32'h0000_0463, 1'b1, 32'h8000_0010, 0, 0, 1'b0, "beq_taken");
   endtask

   task automatic test_ready_stall();
      run_inst(32'h0000_0033, 1'b0, 32'h0, 3, 0, 1'b1, "ready_stall");
   endtask

   task automatic test_wrap();
      run_inst(32'h0000_006F, 1'b0, 32'hFFFF_FFFC, 0, 0, 1'b0, "jal_to_top");
      run_inst(32'h0000_0013, 1'b1, 32'h4444_4444, 0, 1, 1'b0, "pc_wrap");
   endtask

   task automatic test_random();
      logic [6:0]  ops [9];
      logic [31:0] r;
      logic [31:0] word;
      ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
      for (int n = 0; n < 40; n++) begin
         r    = $urandom;
         word = {r[31:7], ops[$urandom_range(8, 0)]};
         run_inst(word, 1'($urandom), $urandom & 32'hFFFF_FFFC,
                  $urandom_range(3, 0), $urandom_range(3, 0), 1'($urandom), "random");
      end
   endtask

   task automatic test_reset_fetch_wait();
      int wait_cnt = 0;
      while (!imem_req_valid && wait_cnt < 40) begin
         step();
         wait_cnt++;
      end
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      rst = 1'b1;
      #1;
      tests++;
      if (pc !== RESET_PC || inst !== 32'd0 || inst_type !== 3'd7 || imem_req_valid !== 1'b0 ||
          rf_we !== 1'b0 || instret !== 32'd0) begin
         fails++;
         $display("FAIL reset_mid_fetch: pc=%h inst=%h type=%0d valid=%b instret=%h",
                  pc, inst, inst_type, imem_req_valid, instret);
      end
      step();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0050_0093;
      step();
      imem_rsp_valid = 1'b0;
      rst = 1'b0;
      m_pc = RESET_PC;
      m_instret = '0;
      tests++;
      if (inst !== 32'd0 || imem_req_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_rsp_ignored: inst=%h valid=%b required 0 0", inst, imem_req_valid);
      end
      step();
      tests++;
      if (imem_req_valid !== 1'b1 || imem_addr !== RESET_PC || inst !== 32'd0) begin
         fails++;
         $display("FAIL first_fetch_after_reset: valid=%b addr=%h inst=%h required 1 %h 0",
                  imem_req_valid, imem_addr, inst, RESET_PC);
      end
   endtask

   task automatic test_instret();
      do_reset();
      for (int n = 0; n < 3; n++)
         run_inst(32'h0010_0093, 1'b0, 32'h0, 0, 0, 1'b0, "instret_seq");
      tests++;
      if (instret !== m_retire_count(32'd3)) begin
         fails++;
         $display("FAIL instret_three: got %h required %h", instret, m_retire_count(32'd3));
      end
   endtask

   task automatic test_halt_ebreak();
      run_inst(EBREAK, 1'b0, 32'h0, 0, 0, 1'b0, "ebreak");
   endtask

   task automatic test_illegal();
      do_reset();
      run_inst(32'h0000_0013, 1'b0, 32'h0, 0, 0, 1'b0, "pre_illegal");
      run_inst(32'h0000_007F, 1'b0, 32'h0, 1, 2, 1'b0, "illegal");
   endtask

   initial begin
      test_reset();
      test_addi();
      test_beq_taken();
      test_ready_stall();
      test_wrap();
      test_random();
      test_reset_fetch_wait();
      test_addi();
      test_instret();
      test_halt_ebreak();
      test_illegal();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
